// File: rtl/aibcr3_avmm2_rx_deframer_if.sv
// Purpose: bundles the AVMM2 RX pad samples, deframer controls and deframer results into one port.
// Ports:   master = deframer side (consumes pad nibbles/rx_en/rx_ready, drives rx_* and counters);
//          slave  = surrounding logic (drives pad samples/rx_en/rx_ready, observes results).
interface aibcr3_avmm2_rx_deframer_if #(
  parameter int PAYLOAD_W = 40,
  parameter int CNT_W     = 16
) ();
  logic [1:0]           avmm2_odat0;  // rising-edge samples, lanes [1:0]
  logic [1:0]           avmm2_odat1;  // falling-edge samples, lanes [1:0]
  logic                 rx_en;
  logic                 rx_ready;
  logic [PAYLOAD_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_err;
  logic                 rx_ovf;
  logic                 rx_busy;
  logic [CNT_W-1:0]     frame_cnt;
  logic [7:0]           err_cnt;

  modport master (
    input  avmm2_odat0, avmm2_odat1, rx_en, rx_ready,
    output rx_data, rx_valid, rx_err, rx_ovf, rx_busy, frame_cnt, err_cnt
  );

  modport slave (
    output avmm2_odat0, avmm2_odat1, rx_en, rx_ready,
    input  rx_data, rx_valid, rx_err, rx_ovf, rx_busy, frame_cnt, err_cnt
  );
endinterface

// File: rtl/aibcr3_avmm2_rx_deframer.sv
// Purpose: assembles SOF-delimited, XOR-checked frames from the AVMM2 RX DDR nibble stream.
// Latency: SOF in cycle 0 -> rx_valid/rx_err/rx_ovf in cycle PAYLOAD_NIBBLES+2.
// Backpressure: single holding register; a good frame arriving while it is full and not
//               being drained is dropped and flagged on rx_ovf.
// Ports: avmm_rx_clk/avmm_rx_rst (sync, active-high) plain; everything else via bus (master).
module aibcr3_avmm2_rx_deframer #(
  parameter int         PAYLOAD_NIBBLES = 10,
  parameter logic [3:0] SOF_NIBBLE      = 4'hF,
  parameter int         CNT_W           = 16
) (
  input  logic                            avmm_rx_clk,
  input  logic                            avmm_rx_rst,
  aibcr3_avmm2_rx_deframer_if.master      bus
);
  localparam int PAYLOAD_W = 4 * PAYLOAD_NIBBLES;
  localparam int NIB_CW    = $clog2(PAYLOAD_NIBBLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;

  state_t               state_q, state_d;
  logic [NIB_CW-1:0]    nib_cnt_q, nib_cnt_d;
  logic [3:0]           acc_q, acc_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [3:0]           nib;

  // Bit 0 = lane 0 rising, bit 1 = lane 0 falling, bit 2 = lane 1 rising, bit 3 = lane 1 falling.
  assign nib = {bus.avmm2_odat1[1], bus.avmm2_odat0[1], bus.avmm2_odat1[0], bus.avmm2_odat0[0]};

  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    ovf_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    // Drain first; a commit below in the same cycle overrides it and refills the register.
    if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_en && nib == SOF_NIBBLE) begin
          state_d   = S_PAYLOAD;
          nib_cnt_d = '0;
          acc_d     = '0;
        end
      end
      S_PAYLOAD: begin
        if (!bus.rx_en) begin
          state_d = S_IDLE;
        end else begin
          // SOF-valued nibbles are plain data here.
          shift_d[{nib_cnt_q, 2'b00} +: 4] = nib;
          acc_d     = acc_q ^ nib;
          nib_cnt_d = nib_cnt_q + NIB_CW'(1);
          if (nib_cnt_q == NIB_CW'(PAYLOAD_NIBBLES - 1)) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (bus.rx_en) begin
          if (nib == acc_q) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (!valid_q || bus.rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge avmm_rx_clk) begin
    if (avmm_rx_rst) begin
      state_q     <= S_IDLE;
      nib_cnt_q   <= '0;
      acc_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_err    = err_q;
  assign bus.rx_ovf    = ovf_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
